// File: rtl/vram_double_buffer.sv
// vram_double_buffer
// Double-buffered video RAM with two banks. The front bank (FRONT_SEL) serves
// scanout reads and the back bank (~FRONT_SEL) takes rasteriser writes.
// A requested flip takes effect on the next FRAME_END seen while idle. A
// built-in clear engine fills the back bank with a constant, one word per
// cycle.
//
// Ports:
//   CLK, RST                sole clock; asynchronous active-high reset
//   WR_EN/WR_ADDR/WR_DATA   back-bank write port (dropped if address >= DEPTH
//                           or WR_READY is low)
//   WR_READY                high when external writes are accepted (idle)
//   RD_EN/RD_ADDR           front-bank read request
//   RD_DATA/RD_VALID        registered read result, 1-cycle latency
//   FRAME_END               end-of-frame pulse from scanout
//   SWAP_REQ                request a flip at the next usable FRAME_END
//   SWAP_DONE               one-cycle pulse when the flip happens
//   CLEAR_REQ/CLEAR_DATA    start a back-bank fill with CLEAR_DATA
//   FRONT_SEL               index of the current front bank
//   BUSY                    clearing, or a swap is pending
module vram_double_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 49152,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_READY,
    input  logic              RD_EN,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    input  logic              FRAME_END,
    input  logic              SWAP_REQ,
    output logic              SWAP_DONE,
    input  logic              CLEAR_REQ,
    input  logic [DATA_W-1:0] CLEAR_DATA,
    output logic              FRONT_SEL,
    output logic              BUSY
);
    // Physical address spans both banks, so it needs one more bit.
    localparam int PA_W = ADDR_W + 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic [DATA_W-1:0] clr_val_reg, clr_val_next;
    logic              swap_pending_reg, swap_pending_next;
    logic              front_sel_reg, front_sel_next;
    logic              swap_done_reg, swap_done_next;
    logic              swap_fire;

    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    logic              mem_we;
    logic [PA_W-1:0]   mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] wr_word;
    logic [PA_W-1:0]   mem_raddr;
    logic              wr_in_range;
    logic              rd_in_range;

    // ---------------- control state ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg        <= IDLE;
            clr_cnt_reg      <= '0;
            clr_val_reg      <= '0;
            swap_pending_reg <= 1'b0;
            front_sel_reg    <= 1'b0;
            swap_done_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            clr_cnt_reg      <= clr_cnt_next;
            clr_val_reg      <= clr_val_next;
            swap_pending_reg <= swap_pending_next;
            front_sel_reg    <= front_sel_next;
            swap_done_reg    <= swap_done_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        clr_cnt_next      = clr_cnt_reg;
        clr_val_next      = clr_val_reg;
        swap_pending_next = swap_pending_reg;
        front_sel_next    = front_sel_reg;
        swap_done_next    = 1'b0;

        // A request arriving in the same cycle as FRAME_END still flips.
        swap_fire = (swap_pending_reg | SWAP_REQ) & FRAME_END & (state_reg == IDLE);

        case (state_reg)
            IDLE: begin
                // Never start erasing a frame that is queued for display.
                if (CLEAR_REQ && !swap_pending_reg) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                    clr_val_next = CLEAR_DATA;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (swap_fire) begin
            front_sel_next    = ~front_sel_reg;
            swap_pending_next = 1'b0;
            swap_done_next    = 1'b1;
        end else if (SWAP_REQ) begin
            swap_pending_next = 1'b1;
        end
    end

    // ---------------- memory write port ----------------
    // The clear engine owns the write port while clearing; external writes
    // are only accepted in IDLE, so the two never collide. The back bank is
    // taken from the registered FRONT_SEL, so a write on a swap edge lands
    // in the old back bank.
    always_comb begin
        wr_in_range = ({1'b0, WR_ADDR} < PA_W'(DEPTH));
        if (state_reg == CLEAR) begin
            mem_we    = 1'b1;
            wr_word   = clr_cnt_reg;
            mem_wdata = clr_val_reg;
        end else begin
            mem_we    = WR_EN & wr_in_range;
            wr_word   = WR_ADDR;
            mem_wdata = WR_DATA;
        end
        mem_waddr = {1'b0, wr_word} + (front_sel_reg ? PA_W'(0) : PA_W'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- memory read port ----------------
    always_comb begin
        rd_in_range = ({1'b0, RD_ADDR} < PA_W'(DEPTH));
        mem_raddr   = {1'b0, RD_ADDR} + (front_sel_reg ? PA_W'(DEPTH) : PA_W'(0));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= RD_EN;
            if (RD_EN) begin
                rd_data_reg <= rd_in_range ? mem[mem_raddr] : '0;
            end
        end
    end

    // ---------------- outputs ----------------
    assign RD_DATA   = rd_data_reg;
    assign RD_VALID  = rd_valid_reg;
    assign SWAP_DONE = swap_done_reg;
    assign FRONT_SEL = front_sel_reg;
    assign WR_READY  = (state_reg == IDLE);
    assign BUSY      = (state_reg == CLEAR) | swap_pending_reg;

endmodule

// File: tb/tb_vram_double_buffer.sv
// Directed testbench for vram_double_buffer with DEPTH=16.
module tb_vram_double_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              frame_end;
    logic              swap_req;
    logic              swap_done;
    logic              clear_req;
    logic [DATA_W-1:0] clear_data;
    logic              front_sel;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vram_double_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(clk), .RST(rst),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_READY(wr_ready),
        .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .FRAME_END(frame_end), .SWAP_REQ(swap_req), .SWAP_DONE(swap_done),
        .CLEAR_REQ(clear_req), .CLEAR_DATA(clear_data),
        .FRONT_SEL(front_sel), .BUSY(busy)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
        frame_end = 0; swap_req = 0; clear_req = 0; clear_data = '0;
        tick(); tick();
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL reset_swap_done got=%b exp=0", swap_done); end
        total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL reset_front_sel got=%b exp=0", front_sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        rst = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    // Write 0xAA to back bank 1 addr 5, flip, read it from the new front.
    task automatic test_basic_swap();
        wr_en = 1; wr_addr = 5'd5; wr_data = 8'hAA;
        tick();
        wr_en = 0; swap_req = 1;
        tick();
        swap_req = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_pending_busy got=%b exp=1", busy); end
        total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%b exp=0", swap_done); end
        frame_end = 1;
        tick();
        frame_end = 0;
        total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL basic_swap_done got=%b exp=1", swap_done); end
        total++; if (front_sel !== 1'b1) begin bad++; $display("FAIL basic_front_sel got=%b exp=1", front_sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        rd_en = 1; rd_addr = 5'd5;
        tick();
        rd_en = 0;
        total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", swap_done); end
        total++; if (rd_data !== 8'hAA) begin bad++; $display("FAIL basic_rd_data got=%h exp=aa", rd_data); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_rd_valid got=%b exp=1", rd_valid); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_rd_valid_drop got=%b exp=0", rd_valid); end
        $display("test_basic_swap: done");
    endtask

    // Clear back bank 0 with 0x3C, try writes during the clear, flip, read all.
    task automatic test_clear();
        int low_cnt;
        clear_req = 1; clear_data = 8'h3C;
        tick();
        clear_req = 0; clear_data = 8'h00;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b exp=1", busy); end
        wr_en = 1; wr_addr = 5'd2; wr_data = 8'h55;
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (wr_ready !== 1'b0) break;
            low_cnt++;
            tick();
        end
        wr_en = 0;
        total++; if (low_cnt != DEPTH) begin bad++; $display("FAIL clear_ready_low_cycles got=%0d exp=%0d", low_cnt, DEPTH); end
        swap_req = 1;
        tick();
        swap_req = 0; frame_end = 1;
        tick();
        frame_end = 0;
        total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL clear_front_sel got=%b exp=0", front_sel); end
        rd_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            tick();
            total++; if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin
                bad++; $display("FAIL clear_read addr=%0d got=%h/%b exp=3c/1", i, rd_data, rd_valid);
            end
        end
        rd_en = 0;
        tick();
        $display("test_clear: done");
    endtask

    // Swap requested mid-clear; FRAME_END mid-clear must not flip.
    task automatic test_swap_during_clear();
        int busy_drop;
        int waited;
        clear_req = 1; clear_data = 8'h11;
        tick();
        clear_req = 0; swap_req = 1;
        tick();
        swap_req = 0;
        tick(); tick();
        frame_end = 1;
        tick();
        frame_end = 0;
        total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL midclear_front_sel got=%b exp=0", front_sel); end
        total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL midclear_swap_done got=%b exp=0", swap_done); end
        busy_drop = 0; waited = 0;
        while (wr_ready !== 1'b1 && waited < 100) begin
            if (busy !== 1'b1) busy_drop++;
            tick();
            waited++;
        end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL midclear_timeout got=%b exp=1", wr_ready); end
        total++; if (busy_drop != 0) begin bad++; $display("FAIL midclear_busy_drops got=%0d exp=0", busy_drop); end
        total++; if (busy !== 1'b1 || front_sel !== 1'b0) begin
            bad++; $display("FAIL midclear_still_pending got=%b/%b exp=1/0", busy, front_sel);
        end
        frame_end = 1;
        tick();
        frame_end = 0;
        total++; if (swap_done !== 1'b1 || front_sel !== 1'b1) begin
            bad++; $display("FAIL midclear_flip got=%b/%b exp=1/1", swap_done, front_sel);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclear_busy_after got=%b exp=0", busy); end
        rd_en = 1; rd_addr = 5'd7;
        tick();
        rd_en = 0;
        total++; if (rd_data !== 8'h11) begin bad++; $display("FAIL midclear_read got=%h exp=11", rd_data); end
        $display("test_swap_during_clear: done");
    endtask

    // Request and FRAME_END together; CLEAR_REQ while pending is ignored.
    task automatic test_same_cycle();
        swap_req = 1; frame_end = 1;
        tick();
        swap_req = 0; frame_end = 0;
        total++; if (swap_done !== 1'b1 || front_sel !== 1'b0) begin
            bad++; $display("FAIL same_cycle_flip got=%b/%b exp=1/0", swap_done, front_sel);
        end
        swap_req = 1;
        tick();
        swap_req = 0; clear_req = 1; clear_data = 8'hEE;
        tick();
        clear_req = 0;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL pending_clear_ignored got=%b exp=1", wr_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pending_busy got=%b exp=1", busy); end
        frame_end = 1;
        tick();
        frame_end = 0;
        total++; if (front_sel !== 1'b1) begin bad++; $display("FAIL pending_flip got=%b exp=1", front_sel); end
        $display("test_same_cycle: done");
    endtask

    // Out-of-range write dropped and out-of-range read returns zero.
    task automatic test_out_of_range();
        wr_en = 1; wr_addr = 5'd16; wr_data = 8'h99;
        tick();
        wr_en = 0; rd_en = 1; rd_addr = 5'd0;
        tick();
        total++; if (rd_data !== 8'h11) begin bad++; $display("FAIL oor_write_dropped got=%h exp=11", rd_data); end
        rd_addr = 5'd19;
        tick();
        rd_en = 0;
        total++; if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin
            bad++; $display("FAIL oor_read got=%h/%b exp=00/1", rd_data, rd_valid);
        end
        $display("test_out_of_range: done");
    endtask

    // Asynchronous reset in the middle of a clear.
    task automatic test_reset_mid_clear();
        int waited;
        rd_en = 1; rd_addr = 5'd0;
        tick();
        rd_en = 0; clear_req = 1; clear_data = 8'h77;
        tick();
        clear_req = 0; swap_req = 1;
        tick();
        swap_req = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL async_rst_ctrl got=%b/%b exp=1/0", wr_ready, busy);
        end
        total++; if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
            bad++; $display("FAIL async_rst_swap got=%b/%b exp=0/0", front_sel, swap_done);
        end
        total++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL async_rst_read got=%h/%b exp=00/0", rd_data, rd_valid);
        end
        #1 rst = 1'b0;
        tick();
        clear_req = 1; clear_data = 8'h42;
        tick();
        clear_req = 0;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL post_rst_clear got=%b exp=0", wr_ready); end
        waited = 0;
        while (wr_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        total++; if (waited != DEPTH) begin bad++; $display("FAIL post_rst_clear_len got=%0d exp=%0d", waited, DEPTH); end
        $display("test_reset_mid_clear: done");
    endtask

    initial begin
        test_reset();
        test_basic_swap();
        test_clear();
        test_swap_during_clear();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_double_buffer.md
# vram_double_buffer

Parametrised, single-clock, double-buffered video RAM that holds a front bank for scanout reads and a back bank for rendering writes. Bank swaps are synchronised to the frame boundary. A built-in clear engine fills the back bank with a constant value. It replaces the flat dual-port VRAM between the rasteriser (write side) and the display scanout (read side), and removes manual base-address juggling for frame flipping.

## Interface
- DATA_W, 8, pixel word width in bits
- DEPTH, 49152, words per bank; total storage 2*DEPTH words, block RAM inferred
- ADDR_W, 16, address width; must satisfy 2^ADDR_W >= DEPTH
- CLK  in  1  sole clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- WR_EN  in  1  write strobe into back bank
- WR_ADDR  in  ADDR_W  back-bank word address
- WR_DATA  in  DATA_W  write data
- WR_READY  out  1  high when external writes are accepted
- RD_EN  in  1  read strobe from front bank
- RD_ADDR  in  ADDR_W  front-bank word address
- RD_DATA  out  DATA_W  registered read data
- RD_VALID  out  1  RD_DATA valid qualifier
- FRAME_END  in  1  single-cycle pulse from scanout at end of frame (vblank start)
- SWAP_REQ  in  1  single-cycle pulse requesting a flip at next FRAME_END
- SWAP_DONE  out  1  single-cycle pulse when a flip has taken effect
- CLEAR_REQ  in  1  single-cycle pulse starting a back-bank clear
- CLEAR_DATA  in  DATA_W  fill value, latched when CLEAR_REQ is accepted
- FRONT_SEL  out  1  index of the current front bank (0 or 1)
- BUSY  out  1  high while clearing or while a swap is pending

## Operation
- Bank b occupies physical words b*DEPTH .. b*DEPTH+DEPTH-1. Back bank = ~FRONT_SEL.
- Write: if WR_EN && WR_READY && WR_ADDR < DEPTH, then MEM[back*DEPTH+WR_ADDR] <= WR_DATA. Writes are dropped silently when WR_ADDR >= DEPTH or WR_READY=0.
- Read: on RD_EN, RD_DATA <= MEM[FRONT_SEL*DEPTH+RD_ADDR] using FRONT_SEL as sampled that cycle. If RD_ADDR >= DEPTH, RD_DATA <= 0. RD_VALID <= RD_EN.
- The FSM has two states, IDLE and CLEAR, plus a separate swap_pending flag.
  - IDLE: CLEAR_REQ with swap_pending=0 latches CLEAR_DATA, sets clr_cnt=0 and goes to CLEAR. CLEAR_REQ is ignored while swap_pending=1, so a frame queued for display is never erased.
  - CLEAR: writes the latched value to back[clr_cnt] each cycle and increments clr_cnt. After the cycle writing DEPTH-1, the FSM returns to IDLE. CLEAR_REQ is ignored in this state.
- WR_READY = (state==IDLE). BUSY = (state==CLEAR) | swap_pending.
- Swap:
  - SWAP_REQ sets swap_pending in any state. A repeated request while pending is a no-op.
  - When swap_pending (or SWAP_REQ in the same cycle) && FRAME_END && state==IDLE: toggle FRONT_SEL, clear swap_pending, pulse SWAP_DONE.
  - FRAME_END during CLEAR does not swap; the pending request waits for the first FRAME_END after the clear finishes.
  - FRAME_END with nothing pending has no effect.
- Memory contents are not reset. RST aborts a clear mid-run and leaves the back bank partially filled.

## Timing
- Reset values: RD_DATA=0, RD_VALID=0, SWAP_DONE=0, FRONT_SEL=0, BUSY=0, WR_READY=1, state=IDLE, swap_pending=0.
- Read latency is 1 cycle: RD_EN at edge n gives RD_DATA/RD_VALID after edge n+1. Back-to-back reads sustain one per cycle.
- Write latency: a write at edge n is visible to a read of the same bank issued at edge n+1 or later (after a swap).
- CLEAR_REQ accepted at edge n:
  - WR_READY and BUSY go low/high after edge n.
  - Clear writes occur at edges n+1 .. n+DEPTH.
  - WR_READY returns high after edge n+DEPTH.
- Swap: FRAME_END at edge n with the request pending gives FRONT_SEL toggled and SWAP_DONE=1 after edge n. SWAP_DONE lasts exactly one cycle. A read at edge n still uses the old bank; a read at n+1 uses the new bank.
- A write at edge n that coincides with a swap targets the old back bank.

## Test plan
- Reset, then write 0xAA to addr 5, SWAP_REQ, FRAME_END, then read addr 5 -> SWAP_DONE pulses once, FRONT_SEL=1, RD_DATA=0xAA one cycle after RD_EN with RD_VALID=1.
- CLEAR_REQ with CLEAR_DATA=0x3C at DEPTH=16 -> WR_READY low for exactly 16 cycles; writes during that window are dropped. After a swap, reads of all 16 addresses return 0x3C.
- SWAP_REQ during a clear, with FRAME_END mid-clear -> no swap. The next FRAME_END after the clear completes flips the bank; BUSY stays high throughout until SWAP_DONE.
- SWAP_REQ and FRAME_END in the same cycle in IDLE -> flip and SWAP_DONE in that cycle. CLEAR_REQ while pending -> ignored, WR_READY stays 1.
- Write to addr DEPTH and read from addr DEPTH+3 -> memory unchanged, RD_DATA=0, RD_VALID=1.
- Assert RST mid-clear -> all outputs return to reset values immediately (asynchronously). After release, CLEAR_REQ is accepted again.
